// File: rtl/player_trail_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : player_trail_gen_if
// Brief    : Game-state to trail-generator bundle, trail arrays back out.
// Revision : 1.0
// ============================================================================
interface player_trail_gen_if #(
    parameter int DEPTH = 41
);
    logic                   frame_tick;
    logic [1:0]             gamemode;
    logic [8:0]             player_y;
    logic [DEPTH-1:0][9:0]  trail_x;
    logic [DEPTH-1:0][8:0]  trail_y;
    logic [DEPTH-1:0][3:0]  trail_life;

    modport master (
        output frame_tick, gamemode, player_y,
        input  trail_x, trail_y, trail_life
    );

    modport slave (
        input  frame_tick, gamemode, player_y,
        output trail_x, trail_y, trail_life
    );
endinterface
`default_nettype wire

// File: rtl/player_trail_gen.sv
`default_nettype none
// ============================================================================
// Module   : player_trail_gen
// Brief    : Per-frame shift buffer of player trail particles (x, y, life).
// Revision : 1.0
// ============================================================================
module player_trail_gen #(
    parameter int DEPTH       = 41,
    parameter int PLAYER_X    = 160,
    parameter int PLAYER_SIZE = 40,
    parameter int MAX_LIFE    = 10,
    parameter int SCROLL      = 4,
    parameter int DECAY_DIV   = 4,
    parameter int UPPER_BOUND = 20,
    parameter int LOWER_BOUND = 460
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    player_trail_gen_if.slave      bus
);

    localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic signed [10:0] c_half = 11'(PLAYER_SIZE / 2);
    localparam logic signed [10:0] c_ymin = 11'(UPPER_BOUND + 1);
    localparam logic signed [10:0] c_ymax = 11'(LOWER_BOUND - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_RUN   = 2'b01,
        ST_HOLD  = 2'b10,
        ST_FADE  = 2'b11
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_clear;
    logic                   w_advance;
    logic                   w_spawn;

    logic [DEPTH-1:0][9:0]  r_x;
    logic [DEPTH-1:0][8:0]  r_y;
    logic [DEPTH-1:0][3:0]  r_life;
    logic [15:0]            r_lfsr;
    logic [DW-1:0]          r_dcnt;

    logic [DEPTH-1:0][9:0]  w_x_nxt;
    logic [DEPTH-1:0][8:0]  w_y_nxt;
    logic [DEPTH-1:0][3:0]  w_life_nxt;
    logic                   w_decay;
    logic                   w_lfsr_fb;
    logic signed [10:0]     w_ysum;
    logic [8:0]             w_y_spawn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ticks act on the mode registered at the previous edge, never the live input.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_advance   = 1'b0;
        w_spawn     = 1'b0;
        case (bus.gamemode)
            2'b00:   w_state_nxt = ST_CLEAR;
            2'b01:   w_state_nxt = ST_RUN;
            2'b10:   w_state_nxt = ST_HOLD;
            default: w_state_nxt = ST_FADE;
        endcase
        case (r_state)
            ST_CLEAR: w_clear = 1'b1;
            ST_RUN: begin
                w_advance = bus.frame_tick;
                w_spawn   = bus.frame_tick;
            end
            ST_FADE:  w_advance = bus.frame_tick;
            default:  w_advance = 1'b0;
        endcase
    end

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_decay   = (r_dcnt == DW'(DECAY_DIV - 1));

    // Jitter lfsr[1:0]-2 spans -2..+1; sum kept signed so low player_y cannot wrap.
    always_comb begin
        w_ysum = $signed({2'b00, bus.player_y}) + c_half
               + $signed({9'd0, r_lfsr[1:0]}) - 11'sd2;
        if (w_ysum < c_ymin) begin
            w_y_spawn = 9'(UPPER_BOUND + 1);
        end else if (w_ysum > c_ymax) begin
            w_y_spawn = 9'(LOWER_BOUND - 1);
        end else begin
            w_y_spawn = w_ysum[8:0];
        end
    end

    always_comb begin
        w_x_nxt    = '0;
        w_y_nxt    = '0;
        w_life_nxt = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_y_nxt[i] = r_y[i-1];
            if (r_x[i-1] < 10'(SCROLL)) begin
                w_x_nxt[i]    = '0;
                w_life_nxt[i] = '0;
            end else begin
                w_x_nxt[i]    = r_x[i-1] - 10'(SCROLL);
                w_life_nxt[i] = (w_decay && (r_life[i-1] != 4'd0))
                              ? r_life[i-1] - 4'd1 : r_life[i-1];
            end
        end
        if (w_spawn) begin
            w_x_nxt[0]    = 10'(PLAYER_X);
            w_y_nxt[0]    = w_y_spawn;
            w_life_nxt[0] = 4'(MAX_LIFE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_life <= '0;
            r_lfsr <= 16'hACE1;
            r_dcnt <= '0;
        end else if (w_clear) begin
            r_x    <= '0;
            r_y    <= '0;
            r_life <= '0;
            r_dcnt <= '0;
        end else if (w_advance) begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_life <= w_life_nxt;
            r_dcnt <= w_decay ? '0 : r_dcnt + DW'(1);
            if (w_spawn) begin
                r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            end
        end
    end

    assign bus.trail_x    = r_x;
    assign bus.trail_y    = r_y;
    assign bus.trail_life = r_life;

endmodule
`default_nettype wire

// File: tb/tb_player_trail_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_trail_gen
// Brief    : Scoreboard bench for player_trail_gen with directed frame ticks.
// Revision : 1.0
// ============================================================================
module tb_player_trail_gen;

    localparam int DEPTH       = 41;
    localparam int PLAYER_X    = 160;
    localparam int PLAYER_SIZE = 40;
    localparam int MAX_LIFE    = 10;
    localparam int SCROLL      = 4;
    localparam int DECAY_DIV   = 4;
    localparam int UPPER_BOUND = 20;
    localparam int LOWER_BOUND = 460;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;

    player_trail_gen_if #(.DEPTH(DEPTH)) bus ();

    player_trail_gen #(
        .DEPTH(DEPTH), .PLAYER_X(PLAYER_X), .PLAYER_SIZE(PLAYER_SIZE),
        .MAX_LIFE(MAX_LIFE), .SCROLL(SCROLL), .DECAY_DIV(DECAY_DIV),
        .UPPER_BOUND(UPPER_BOUND), .LOWER_BOUND(LOWER_BOUND)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                     stamp;
        bit                     full;
        string                  name;
        int                     idx;
        int                     xv;
        int                     ylo;
        int                     yhi;
        int                     lv;
        logic [DEPTH-1:0][9:0]  ex;
        logic [DEPTH-1:0][8:0]  ey;
        logic [DEPTH-1:0][3:0]  el;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int          m_x [DEPTH];
    int          m_y [DEPTH];
    int          m_l [DEPTH];
    logic [15:0] m_lfsr;
    int          m_dc;
    int          m_mode;
    int          last_stamp;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_l[i] = 0;
        end
        m_dc = 0;
    endtask

    task automatic model_tick(input int mode, input int py);
        bit dec;
        int ox;
        int ol;
        int yy;
        if (mode == 1 || mode == 3) begin
            dec = (m_dc == DECAY_DIV - 1);
            for (int i = DEPTH - 1; i >= 1; i--) begin
                ox = m_x[i-1];
                ol = m_l[i-1];
                if (ox < SCROLL) begin
                    m_x[i] = 0; m_l[i] = 0;
                end else begin
                    m_x[i] = ox - SCROLL;
                    m_l[i] = (dec && ol > 0) ? ol - 1 : ol;
                end
                m_y[i] = m_y[i-1];
            end
            if (mode == 1) begin
                yy = py + PLAYER_SIZE / 2 + int'(m_lfsr & 16'h3) - 2;
                if (yy < UPPER_BOUND + 1) yy = UPPER_BOUND + 1;
                if (yy > LOWER_BOUND - 1) yy = LOWER_BOUND - 1;
                m_x[0] = PLAYER_X; m_y[0] = yy; m_l[0] = MAX_LIFE;
                m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
            end else begin
                m_x[0] = 0; m_y[0] = 0; m_l[0] = 0;
            end
            m_dc = (m_dc + 1) % DECAY_DIV;
        end
    endtask

    task automatic push_full(input int stamp, input string name);
        exp_t e;
        e.stamp = stamp; e.full = 1'b1; e.name = name;
        e.idx = 0; e.xv = -1; e.ylo = -1; e.yhi = -1; e.lv = -1;
        for (int i = 0; i < DEPTH; i++) begin
            e.ex[i] = 10'(m_x[i]);
            e.ey[i] = 9'(m_y[i]);
            e.el[i] = 4'(m_l[i]);
        end
        exp_q.push_back(e);
    endtask

    task automatic push_point(input string name, input int idx, input int xv,
                              input int ylo, input int yhi, input int lv);
        exp_t e;
        e.stamp = last_stamp; e.full = 1'b0; e.name = name;
        e.idx = idx; e.xv = xv; e.ylo = ylo; e.yhi = yhi; e.lv = lv;
        e.ex = '0; e.ey = '0; e.el = '0;
        exp_q.push_back(e);
    endtask

    task automatic set_mode(input int m);
        @(negedge clk);
        bus.gamemode = 2'(m);
        repeat (2) @(negedge clk);
        m_mode = m;
    endtask

    // new_mode >= 0 changes gamemode on the same edge as the tick.
    task automatic tick(input int py, input int new_mode, input string name);
        @(negedge clk);
        bus.player_y   = 9'(py);
        bus.frame_tick = 1'b1;
        if (new_mode >= 0) bus.gamemode = 2'(new_mode);
        model_tick(m_mode, py);
        last_stamp = cyc + 1;
        push_full(last_stamp, name);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        if (new_mode >= 0) m_mode = new_mode;
    endtask

    task automatic check_item(input exp_t e);
        int d;
        int ya;
        if (e.full) begin
            n_vec++;
            if (bus.trail_x !== e.ex) begin
                n_err++;
                d = 0;
                while (d < DEPTH - 1 && bus.trail_x[d] === e.ex[d]) d++;
                $display("FAIL %s trail_x[%0d]: got %0d, expected %0d", e.name, d, bus.trail_x[d], e.ex[d]);
            end
            n_vec++;
            if (bus.trail_y !== e.ey) begin
                n_err++;
                d = 0;
                while (d < DEPTH - 1 && bus.trail_y[d] === e.ey[d]) d++;
                $display("FAIL %s trail_y[%0d]: got %0d, expected %0d", e.name, d, bus.trail_y[d], e.ey[d]);
            end
            n_vec++;
            if (bus.trail_life !== e.el) begin
                n_err++;
                d = 0;
                while (d < DEPTH - 1 && bus.trail_life[d] === e.el[d]) d++;
                $display("FAIL %s trail_life[%0d]: got %0d, expected %0d", e.name, d, bus.trail_life[d], e.el[d]);
            end
        end else begin
            if (e.xv >= 0) begin
                n_vec++;
                if (bus.trail_x[e.idx] !== 10'(e.xv)) begin
                    n_err++;
                    $display("FAIL %s x[%0d]: got %0d, expected %0d", e.name, e.idx, bus.trail_x[e.idx], e.xv);
                end
            end
            if (e.ylo >= 0) begin
                n_vec++;
                ya = int'(bus.trail_y[e.idx]);
                if ($isunknown(bus.trail_y[e.idx]) || ya < e.ylo || ya > e.yhi) begin
                    n_err++;
                    $display("FAIL %s y[%0d]: got %0d, expected %0d..%0d", e.name, e.idx, ya, e.ylo, e.yhi);
                end
            end
            if (e.lv >= 0) begin
                n_vec++;
                if (bus.trail_life[e.idx] !== 4'(e.lv)) begin
                    n_err++;
                    $display("FAIL %s life[%0d]: got %0d, expected %0d", e.name, e.idx, bus.trail_life[e.idx], e.lv);
                end
            end
        end
    endtask

    // Monitor: compares queued expectations once their update edge has passed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
                e = exp_q.pop_front();
                check_item(e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.gamemode   = 2'b01;
        bus.player_y   = 9'd200;
        m_lfsr = 16'hACE1; m_mode = 1; last_stamp = 0;
        model_reset();

        // Reset state
        @(negedge clk);
        push_full(cyc + 1, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First spawn: ACE1 -> jitter -1 -> y = 219
        tick(200, -1, "spawn1");
        push_point("spawn1_e0", 0, 160, 219, 219, 10);
        push_point("spawn1_e1", 1, 0, -1, -1, 0);
        tick(200, -1, "spawn2");
        tick(200, -1, "spawn3");
        push_point("drift_e0", 0, 160, 218, 221, 10);
        push_point("drift_e1", 1, 156, -1, -1, 10);
        push_point("drift_e2", 2, 152, -1, -1, 10);
        tick(200, -1, "decay4");
        push_point("decay_e3", 3, 148, -1, -1, 9);
        push_point("decay_e1", 1, 156, -1, -1, 9);

        for (int k = 0; k < 5; k++) tick(100 + 37 * k, -1, "run");

        // Mode change coincident with a tick: this tick still runs
        tick(250, 2, "tick_to_hold");
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) tick(300, -1, "hold");
        set_mode(1);
        for (int k = 0; k < 4; k++) tick(220 + k, -1, "resume");

        // Clamp boundaries
        tick(0, -1, "clamp_lo");
        push_point("clamp_lo_e0", 0, 160, 21, 21, 10);
        tick(440, -1, "clamp_hi");
        push_point("clamp_hi_e0", 0, 160, 458, 459, 10);

        // Asynchronous reset mid-RUN with a populated array
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        m_lfsr = 16'hACE1;
        push_full(cyc + 1, "reset_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tick(200, -1, "post_reset");
        push_point("post_reset_e0", 0, 160, 219, 219, 10);
        for (int k = 0; k < 6; k++) tick(60 + 50 * k, -1, "refill");

        // Fade drains the trail without spawning
        set_mode(3);
        for (int k = 0; k < DEPTH; k++) tick(200, -1, "fade");
        push_point("fade_e0", 0, 0, 0, 0, 0);
        push_point("fade_last", DEPTH - 1, -1, -1, -1, 0);

        // Clear with no tick: zero two edges after gamemode changes
        set_mode(1);
        for (int k = 0; k < 3; k++) tick(180, -1, "pre_clear");
        @(negedge clk);
        bus.gamemode = 2'b00;
        model_reset();
        push_full(cyc + 2, "clear");
        repeat (3) @(negedge clk);
        m_mode = 0;
        tick(200, -1, "tick_in_clear");
        set_mode(1);
        for (int k = 0; k < 3; k++) tick(210, -1, "after_clear");

        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err += exp_q.size();
            $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
